// File: rtl/ring_buffer_pkg.sv
// Shared definitions for the ring buffer read-side burst controller.
package ring_buffer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_POP   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } readerState_e;

   // The skid store is two deep so it covers the one-cycle read latency of the buffer
   localparam int SKID_DEPTH = 2;
   localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/reader_skid_fifo.sv
// Two-entry store that holds popped buffer entries until the consumer takes them.
// The parent never pushes into a full store, so there is no overflow guard here.
module reader_skid_fifo
   import ring_buffer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  i_push,
   input  logic [WIDTH-1:0]      i_data,
   input  logic                  i_pop,
   output logic [WIDTH-1:0]      o_data,
   output logic [SKID_CNT_W-1:0] o_count
);

   logic [WIDTH-1:0]      r_mem [SKID_DEPTH];
   logic                  r_wrPtr;
   logic                  r_rdPtr;
   logic [SKID_CNT_W-1:0] r_count;

   assign o_data  = r_mem[r_rdPtr];
   assign o_count = r_count;

   // Storage, pointers and occupancy; a push and a pop in the same cycle leave the count unchanged
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < SKID_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wrPtr <= 1'b0;
         r_rdPtr <= 1'b0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wrPtr] <= i_data;
            r_wrPtr        <= ~r_wrPtr;
         end
         if (i_pop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ring_buffer_burst_reader.sv
// Pops a programmed number of entries from a ring buffer and streams them out
// on a valid/ready interface, flagging the final beat of each burst.
module ring_buffer_burst_reader
   import ring_buffer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             busy_o,
   output logic             done_o,
   input  logic             q_empty_i,
   output logic             q_dequeue_o,
   input  logic [WIDTH-1:0] q_data_i,
   output logic             m_valid_o,
   input  logic             m_ready_i,
   output logic [WIDTH-1:0] m_data_o,
   output logic             m_last_o
);

   localparam logic [SKID_CNT_W:0] DEPTH_V = (SKID_CNT_W + 1)'(SKID_DEPTH);

   readerState_e          r_state;
   logic [LEN_W-1:0]      r_popRem;
   logic [LEN_W-1:0]      r_beatRem;
   logic                  r_inflight;
   logic                  r_busy;
   logic                  r_done;

   logic [SKID_CNT_W-1:0] w_count;
   logic [WIDTH-1:0]      w_head;
   logic                  w_fire;
   logic                  w_dequeue;
   logic [SKID_CNT_W:0]   w_occupancy;
   logic [SKID_CNT_W:0]   w_limit;

   assign m_valid_o = (w_count != '0);
   assign m_data_o  = w_head;
   assign m_last_o  = m_valid_o && (r_beatRem == LEN_W'(1));
   assign w_fire    = m_valid_o && m_ready_i;

   // A pop is allowed only if the entry it returns is sure to find a free slot
   assign w_occupancy = {1'b0, w_count} + {{SKID_CNT_W{1'b0}}, r_inflight};
   assign w_limit     = DEPTH_V + {{SKID_CNT_W{1'b0}}, w_fire};
   assign w_dequeue   = (r_state == ST_POP) && (r_popRem != '0) && !q_empty_i
                        && (w_occupancy < w_limit);

   assign q_dequeue_o = w_dequeue;
   assign busy_o      = r_busy;
   assign done_o      = r_done;

   // Remember a pop so its data, valid during the following cycle, gets captured
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_dequeue;
      end
   end

   // Burst sequencing with registered busy/done flags kept in step with the state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= ST_IDLE;
         r_popRem  <= '0;
         r_beatRem <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  r_popRem  <= len_i;
                  r_beatRem <= len_i;
                  r_busy    <= 1'b1;
                  if (len_i == '0) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_POP;
                  end
               end
            end
            ST_POP: begin
               if (w_dequeue) begin
                  r_popRem <= r_popRem - 1'b1;
                  if (r_popRem == LEN_W'(1)) begin
                     r_state <= ST_DRAIN;
                  end
               end
               if (w_fire) begin
                  r_beatRem <= r_beatRem - 1'b1;
               end
            end
            ST_DRAIN: begin
               if (w_fire) begin
                  r_beatRem <= r_beatRem - 1'b1;
                  if (r_beatRem == LEN_W'(1)) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   reader_skid_fifo #(
      .WIDTH (WIDTH)
   ) skidFifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_push  (r_inflight),
      .i_data  (q_data_i),
      .i_pop   (w_fire),
      .o_data  (w_head),
      .o_count (w_count)
   );

endmodule
